trap_ctrl: RTL and testbench
============================

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  core clock, single domain; all state changes on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have inputs: timer_irq 1 (level), ext_irq 1 (level), csr_mie 1 (mstatus.MIE), csr_mtie 1, csr_meie 1.
REQ-004 SHALL have inputs: csr_mtvec 32, csr_mepc 32, resume_pc 32 (PC of oldest uncommitted instr), pipe_stall 1, mret_ex 1 (MRET in EX).
REQ-005 SHALL have outputs: trap_timer 1, trap_ext 1 (one-cycle PC-force pulses), redirect 1, redirect_pc 32, flush 1.
REQ-006 SHALL have outputs: mepc_we 1, mepc_wdata 32, mcause_we 1, mcause_wdata 32, mstatus_trap 1 (MPIE<-MIE, MIE<-0), mstatus_ret 1 (MIE<-MPIE, MPIE<-1), busy 1.
REQ-007 SHALL drive every output from a register; no input-to-output combinational path.

Function
REQ-008 SHALL implement FSM states IDLE, WAIT, TAKE, RET, SETTLE.
REQ-009 SHALL define pend_ext = ext_irq & csr_meie & csr_mie; pend_tmr = timer_irq & csr_mtie & csr_mie; pending = pend_ext | pend_tmr.
REQ-010 IDLE: mret_ex & ~pipe_stall -> RET; else pending & ~pipe_stall -> TAKE; else pending & pipe_stall -> WAIT; else stay.
REQ-011 SHALL give mret_ex priority over pending in the same cycle; the interrupt is re-evaluated after SETTLE.
REQ-012 WAIT: ~pending -> IDLE with no trap; pending & ~pipe_stall -> TAKE; else stay.
REQ-013 SHALL give ext over timer priority; cause latched on the edge entering TAKE: ext -> 0x8000000B, timer -> 0x80000007.
REQ-014 On entering TAKE SHALL latch mepc_wdata = resume_pc and redirect_pc = {csr_mtvec[31:2], 2'b00}.
REQ-015 TAKE (exactly one cycle): redirect=1, flush=1, mepc_we=1, mcause_we=1, mstatus_trap=1, trap_ext or trap_timer=1 per latched cause (never both) -> SETTLE.
REQ-016 On entering RET SHALL latch redirect_pc = csr_mepc.
REQ-017 RET (exactly one cycle): redirect=1, flush=1, mstatus_ret=1, other pulses 0 -> SETTLE.
REQ-018 SETTLE: one cycle, all pulses 0, inputs ignored -> IDLE unconditionally.
REQ-019 SHALL hold every pulse output at 0 outside its state; redirect_pc/mepc_wdata/mcause_wdata keep last latched value.
REQ-020 busy SHALL be 1 in WAIT, TAKE, RET, SETTLE; 0 in IDLE.
REQ-021 Latency: decision edge at cycle N (pending, unstalled, IDLE/WAIT) -> pulses visible cycle N+1 -> IDLE at N+3.
REQ-022 pipe_stall asserted while in TAKE or RET SHALL NOT extend or suppress the pulse.
REQ-023 irq deasserting after the TAKE decision SHALL NOT cancel the trap.

Reset
REQ-024 rst=1 SHALL force IDLE and all outputs 0 (incl. redirect_pc, mepc_wdata, mcause_wdata = 0x00000000) on the next edge, from any state.
REQ-025 rst SHALL take priority over every input, including during WAIT/TAKE/RET.
REQ-026 First decision after rst deassertion SHALL occur on the first edge with rst=0.

Verification
REQ-027 Timer: csr_mie=1, csr_mtie=1, timer_irq=1, pipe_stall=0, resume_pc=0x00000100, mtvec=0x00010003 -> next cycle trap_timer=1, redirect_pc=0x00010000, mepc_wdata=0x00000100, mcause_wdata=0x80000007, single-cycle pulses.
REQ-028 Simultaneous ext_irq+timer_irq, both enabled -> trap_ext=1, trap_timer=0, mcause_wdata=0x8000000B.
REQ-029 Stall: irq pending with pipe_stall=1 for 3 cycles -> busy=1, no pulses; stall drops -> pulses next cycle; irq dropped mid-WAIT -> IDLE, no pulses.
REQ-030 MRET + pending timer same cycle, csr_mepc=0x00000200 -> RET first: redirect_pc=0x00000200, mstatus_ret=1, trap_timer=0.
REQ-031 rst=1 asserted in the WAIT/TAKE cycle -> next cycle all outputs 0, busy=0, no trap pulse.
REQ-032 csr_mie=0 with timer_irq=1 for 10 cycles -> FSM stays IDLE, all outputs 0.

Source files
------------

// File: rtl/trap_ctrl.sv
// Machine-mode interrupt entry / MRET return sequencer. Decides when a pending
// interrupt or an MRET may redirect the pipeline and emits one-cycle CSR-update pulses.
module trap_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        timer_irq,
   input  logic        ext_irq,
   input  logic        csr_mie,
   input  logic        csr_mtie,
   input  logic        csr_meie,
   input  logic [31:0] csr_mtvec,
   input  logic [31:0] csr_mepc,
   input  logic [31:0] resume_pc,
   input  logic        pipe_stall,
   input  logic        mret_ex,
   output logic        trap_timer,
   output logic        trap_ext,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic        flush,
   output logic        mepc_we,
   output logic [31:0] mepc_wdata,
   output logic        mcause_we,
   output logic [31:0] mcause_wdata,
   output logic        mstatus_trap,
   output logic        mstatus_ret,
   output logic        busy
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WAIT   = 3'd1,
      ST_TAKE   = 3'd2,
      ST_RET    = 3'd3,
      ST_SETTLE = 3'd4
   } state_t;

   localparam logic [31:0] CAUSE_EXT = 32'h8000_000B;
   localparam logic [31:0] CAUSE_TMR = 32'h8000_0007;

   state_t      state_r;
   logic        pend_ext_s;
   logic        pend_tmr_s;
   logic        pending_s;

   logic        trap_timer_r;
   logic        trap_ext_r;
   logic        redirect_r;
   logic [31:0] redirect_pc_r;
   logic        flush_r;
   logic        mepc_we_r;
   logic [31:0] mepc_wdata_r;
   logic        mcause_we_r;
   logic [31:0] mcause_wdata_r;
   logic        mstatus_trap_r;
   logic        mstatus_ret_r;
   logic        busy_r;

   // External interrupts outrank the timer when both are pending.
   function automatic logic [31:0] cause_of(input logic ext_sel);
      if (ext_sel) begin
         cause_of = CAUSE_EXT;
      end else begin
         cause_of = CAUSE_TMR;
      end
   endfunction

   // Qualify the raw interrupt lines with their enables.
   always_comb begin
      pend_ext_s = ext_irq & csr_meie & csr_mie;
      pend_tmr_s = timer_irq & csr_mtie & csr_mie;
      pending_s  = pend_ext_s | pend_tmr_s;
   end

   // Sequencer state and every output register; pulses are set on the edge entering their state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= ST_IDLE;
         trap_timer_r   <= 1'b0;
         trap_ext_r     <= 1'b0;
         redirect_r     <= 1'b0;
         redirect_pc_r  <= 32'h0000_0000;
         flush_r        <= 1'b0;
         mepc_we_r      <= 1'b0;
         mepc_wdata_r   <= 32'h0000_0000;
         mcause_we_r    <= 1'b0;
         mcause_wdata_r <= 32'h0000_0000;
         mstatus_trap_r <= 1'b0;
         mstatus_ret_r  <= 1'b0;
         busy_r         <= 1'b0;
      end else begin
         trap_timer_r   <= 1'b0;
         trap_ext_r     <= 1'b0;
         redirect_r     <= 1'b0;
         flush_r        <= 1'b0;
         mepc_we_r      <= 1'b0;
         mcause_we_r    <= 1'b0;
         mstatus_trap_r <= 1'b0;
         mstatus_ret_r  <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (mret_ex && !pipe_stall) begin
                  state_r       <= ST_RET;
                  redirect_pc_r <= csr_mepc;
                  redirect_r    <= 1'b1;
                  flush_r       <= 1'b1;
                  mstatus_ret_r <= 1'b1;
                  busy_r        <= 1'b1;
               end else if (pending_s && !pipe_stall) begin
                  state_r        <= ST_TAKE;
                  redirect_pc_r  <= {csr_mtvec[31:2], 2'b00};
                  mepc_wdata_r   <= resume_pc;
                  mcause_wdata_r <= cause_of(pend_ext_s);
                  trap_ext_r     <= pend_ext_s;
                  trap_timer_r   <= ~pend_ext_s;
                  redirect_r     <= 1'b1;
                  flush_r        <= 1'b1;
                  mepc_we_r      <= 1'b1;
                  mcause_we_r    <= 1'b1;
                  mstatus_trap_r <= 1'b1;
                  busy_r         <= 1'b1;
               end else if (pending_s) begin
                  state_r <= ST_WAIT;
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end
            end
            ST_WAIT: begin
               // A withdrawn interrupt abandons the wait without any trap.
               if (!pending_s) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end else if (!pipe_stall) begin
                  state_r        <= ST_TAKE;
                  redirect_pc_r  <= {csr_mtvec[31:2], 2'b00};
                  mepc_wdata_r   <= resume_pc;
                  mcause_wdata_r <= cause_of(pend_ext_s);
                  trap_ext_r     <= pend_ext_s;
                  trap_timer_r   <= ~pend_ext_s;
                  redirect_r     <= 1'b1;
                  flush_r        <= 1'b1;
                  mepc_we_r      <= 1'b1;
                  mcause_we_r    <= 1'b1;
                  mstatus_trap_r <= 1'b1;
                  busy_r         <= 1'b1;
               end else begin
                  state_r <= ST_WAIT;
                  busy_r  <= 1'b1;
               end
            end
            ST_TAKE: begin
               state_r <= ST_SETTLE;
               busy_r  <= 1'b1;
            end
            ST_RET: begin
               state_r <= ST_SETTLE;
               busy_r  <= 1'b1;
            end
            ST_SETTLE: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign trap_timer   = trap_timer_r;
   assign trap_ext     = trap_ext_r;
   assign redirect     = redirect_r;
   assign redirect_pc  = redirect_pc_r;
   assign flush        = flush_r;
   assign mepc_we      = mepc_we_r;
   assign mepc_wdata   = mepc_wdata_r;
   assign mcause_we    = mcause_we_r;
   assign mcause_wdata = mcause_wdata_r;
   assign mstatus_trap = mstatus_trap_r;
   assign mstatus_ret  = mstatus_ret_r;
   assign busy         = busy_r;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios then random traffic, every output
// compared each cycle against a reference built from the trap/return rules.
module tb_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst, timer_irq, ext_irq, csr_mie, csr_mtie, csr_meie;
   logic [31:0] csr_mtvec, csr_mepc, resume_pc;
   logic        pipe_stall, mret_ex;
   logic        trap_timer, trap_ext, redirect, flush, mepc_we, mcause_we;
   logic        mstatus_trap, mstatus_ret, busy;
   logic [31:0] redirect_pc, mepc_wdata, mcause_wdata;

   int tests_run = 0;
   int tests_failed = 0;

   // reference model state: cycles left in a redirect sequence, and "waiting on stall"
   int          m_left = 0;
   bit          m_waiting = 1'b0;
   bit          e_tt, e_te, e_rd, e_fl, e_mw, e_cw, e_st, e_sr, e_busy;
   logic [31:0] e_pc = 32'h0, e_mepc = 32'h0, e_cause = 32'h0;

   trap_ctrl dut (
      .clk(clk), .rst(rst), .timer_irq(timer_irq), .ext_irq(ext_irq),
      .csr_mie(csr_mie), .csr_mtie(csr_mtie), .csr_meie(csr_meie),
      .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc), .resume_pc(resume_pc),
      .pipe_stall(pipe_stall), .mret_ex(mret_ex),
      .trap_timer(trap_timer), .trap_ext(trap_ext), .redirect(redirect),
      .redirect_pc(redirect_pc), .flush(flush), .mepc_we(mepc_we),
      .mepc_wdata(mepc_wdata), .mcause_we(mcause_we), .mcause_wdata(mcause_wdata),
      .mstatus_trap(mstatus_trap), .mstatus_ret(mstatus_ret), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Expected outputs after the coming edge, from the inputs currently applied.
   task automatic model_edge();
      bit pe, pt;
      pe = ext_irq & csr_meie & csr_mie;
      pt = timer_irq & csr_mtie & csr_mie;
      {e_tt, e_te, e_rd, e_fl, e_mw, e_cw, e_st, e_sr} = 8'h00;
      if (rst) begin
         m_left = 0; m_waiting = 1'b0; e_busy = 1'b0;
         e_pc = 32'h0; e_mepc = 32'h0; e_cause = 32'h0;
      end else if (m_left > 0) begin
         m_left--;
         e_busy = (m_left > 0);
      end else if (!m_waiting && mret_ex && !pipe_stall) begin
         e_rd = 1'b1; e_fl = 1'b1; e_sr = 1'b1; e_busy = 1'b1;
         e_pc = csr_mepc; m_left = 2;
      end else if ((pe || pt) && !pipe_stall) begin
         e_rd = 1'b1; e_fl = 1'b1; e_mw = 1'b1; e_cw = 1'b1; e_st = 1'b1; e_busy = 1'b1;
         e_te = pe; e_tt = !pe;
         e_cause = pe ? 32'h8000_000B : 32'h8000_0007;
         e_pc = {csr_mtvec[31:2], 2'b00};
         e_mepc = resume_pc;
         m_left = 2; m_waiting = 1'b0;
      end else if (pe || pt) begin
         m_waiting = 1'b1; e_busy = 1'b1;
      end else begin
         m_waiting = 1'b0; e_busy = 1'b0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("trap_timer", 32'(trap_timer), 32'(e_tt));
      chk("trap_ext", 32'(trap_ext), 32'(e_te));
      chk("redirect", 32'(redirect), 32'(e_rd));
      chk("flush", 32'(flush), 32'(e_fl));
      chk("mepc_we", 32'(mepc_we), 32'(e_mw));
      chk("mcause_we", 32'(mcause_we), 32'(e_cw));
      chk("mstatus_trap", 32'(mstatus_trap), 32'(e_st));
      chk("mstatus_ret", 32'(mstatus_ret), 32'(e_sr));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("redirect_pc", redirect_pc, e_pc);
      chk("mepc_wdata", mepc_wdata, e_mepc);
      chk("mcause_wdata", mcause_wdata, e_cause);
   endtask

   task automatic quiet();
      rst = 1'b0; timer_irq = 1'b0; ext_irq = 1'b0; pipe_stall = 1'b0; mret_ex = 1'b0;
      csr_mie = 1'b1; csr_mtie = 1'b1; csr_meie = 1'b1;
   endtask

   initial begin
      quiet();
      csr_mtvec = 32'h0; csr_mepc = 32'h0; resume_pc = 32'h0;
      rst = 1'b1;
      step(); step();
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_pc", redirect_pc, 32'h0);
      rst = 1'b0;

      // Timer trap with misaligned mtvec
      timer_irq = 1'b1; resume_pc = 32'h0000_0100; csr_mtvec = 32'h0001_0003;
      step();
      chk("tmr_pulse", 32'(trap_timer), 32'h1);
      chk("tmr_pc", redirect_pc, 32'h0001_0000);
      chk("tmr_mepc", mepc_wdata, 32'h0000_0100);
      chk("tmr_cause", mcause_wdata, 32'h8000_0007);
      timer_irq = 1'b0;
      step();
      chk("tmr_single", 32'(trap_timer), 32'h0);
      step(); step();

      // Simultaneous sources: external wins
      timer_irq = 1'b1; ext_irq = 1'b1;
      step();
      chk("both_ext", 32'(trap_ext), 32'h1);
      chk("both_tmr", 32'(trap_timer), 32'h0);
      chk("both_cause", mcause_wdata, 32'h8000_000B);
      quiet(); step(); step(); step();

      // Stall for three cycles, then release
      timer_irq = 1'b1; pipe_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_busy", 32'(busy), 32'h1);
         chk("stall_nopulse", 32'(trap_timer), 32'h0);
      end
      pipe_stall = 1'b0;
      step();
      chk("stall_release", 32'(trap_timer), 32'h1);
      quiet(); step(); step(); step();

      // Interrupt withdrawn while waiting
      ext_irq = 1'b1; pipe_stall = 1'b1;
      step(); step();
      ext_irq = 1'b0;
      step();
      chk("drop_busy", 32'(busy), 32'h0);
      pipe_stall = 1'b0;
      step();
      chk("drop_nopulse", 32'(trap_ext), 32'h0);

      // MRET beats a pending timer; timer then taken after settling
      mret_ex = 1'b1; timer_irq = 1'b1; csr_mepc = 32'h0000_0200;
      step();
      chk("mret_pc", redirect_pc, 32'h0000_0200);
      chk("mret_ret", 32'(mstatus_ret), 32'h1);
      chk("mret_notrap", 32'(trap_timer), 32'h0);
      mret_ex = 1'b0;
      step(); step(); step();
      quiet(); step(); step();

      // Reset during WAIT and during TAKE
      timer_irq = 1'b1; pipe_stall = 1'b1;
      step();
      rst = 1'b1;
      step();
      chk("rst_wait_busy", 32'(busy), 32'h0);
      rst = 1'b0; pipe_stall = 1'b0;
      step();
      rst = 1'b1;
      step();
      chk("rst_take_pulse", 32'(trap_timer), 32'h0);
      chk("rst_take_pc", redirect_pc, 32'h0);
      quiet();

      // Globally masked interrupts
      csr_mie = 1'b0; timer_irq = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("mie_off_busy", 32'(busy), 32'h0);
      end
      quiet();

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         rst        = ($urandom_range(0, 99) < 2);
         pipe_stall = ($urandom_range(0, 99) < 35);
         mret_ex    = ($urandom_range(0, 99) < 10);
         if ($urandom_range(0, 99) < 15) timer_irq = ~timer_irq;
         if ($urandom_range(0, 99) < 12) ext_irq = ~ext_irq;
         csr_mie    = ($urandom_range(0, 99) < 85);
         csr_mtie   = ($urandom_range(0, 99) < 80);
         csr_meie   = ($urandom_range(0, 99) < 80);
         csr_mtvec  = $urandom;
         csr_mepc   = $urandom;
         resume_pc  = $urandom;
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
